// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD conversion and seven-segment display block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: conversion FSM state enum, digit count, active-low segment patterns (bit 6 = g .. bit 0 = a).
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 5;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int BIN_W      = 16;

    // Active-low segment patterns, gfedcba.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Seven-segment lookup: one BCD code to an active-low gfedcba pattern; non-decimal codes go dark.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input code.
// Ports: in_code [3:0] digit code; out_seg [6:0] active-low segments (bit 6 = g .. bit 0 = a).
module seg7_decoder
    import bcd_pkg::*;
(
    input  logic [3:0] in_code,
    output logic [6:0] out_seg
);

    always_comb begin
        out_seg = SEG_BLANK;
        case (in_code)
            4'd0:    out_seg = SEG_0;
            4'd1:    out_seg = SEG_1;
            4'd2:    out_seg = SEG_2;
            4'd3:    out_seg = SEG_3;
            4'd4:    out_seg = SEG_4;
            4'd5:    out_seg = SEG_5;
            4'd6:    out_seg = SEG_6;
            4'd7:    out_seg = SEG_7;
            4'd8:    out_seg = SEG_8;
            4'd9:    out_seg = SEG_9;
            default: out_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_controller.sv
// 16-bit binary to 5-digit BCD converter (shift-add-3) driving a multiplexed 5-digit seven-segment display.
// Latency: start edge to out_done is 17 cycles (16 CONVERT cycles, then one DONE cycle); scanner is free-running.
// Backpressure: none; in_start is only honoured in IDLE, requests arriving while busy or done are dropped.
// Ports: in_clk clock; in_reset_n sync active-low reset; in_value/in_start conversion request;
//        in_blank_zeros leading-zero blanking; out_busy/out_done status; out_bcd_value registered result;
//        out_seg active-low segments; out_an active-low digit enables (bit 0 = units).
module bcd_display_controller
    import bcd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
)
(
    input  logic                  in_clk,
    input  logic                  in_reset_n,
    input  logic [BIN_W-1:0]      in_value,
    input  logic                  in_start,
    input  logic                  in_blank_zeros,
    output logic                  out_busy,
    output logic                  out_done,
    output logic [BCD_W-1:0]      out_bcd_value,
    output logic [6:0]            out_seg,
    output logic [NUM_DIGITS-1:0] out_an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    // ---------------- conversion FSM ----------------
    state_e           state_q, state_d;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0] acc_q,   acc_d;
    logic [BCD_W-1:0] adj;
    logic [3:0]       cnt_q,   cnt_d;
    logic [BCD_W-1:0] bcd_q,   bcd_d;

    // Pre-shift correction: any nibble >= 5 would reach >= 10 after doubling, so bias it by 3
    // to make the carry into the next decade happen on the shift.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    shift_d = in_value;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                {acc_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    // Last bit shifted in: the freshly shifted accumulator is the final result.
                    bcd_d   = acc_d;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign out_busy      = (state_q == ST_CONVERT);
    assign out_done      = (state_q == ST_DONE);
    assign out_bcd_value = bcd_q;

    // ---------------- display scanner ----------------
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    dig_q,   dig_d;
    logic [3:0]    cur_code;
    logic          blank_cur;
    logic [6:0]    seg_raw;
    logic [NUM_DIGITS-1:0] an_sel;

    always_comb begin
        presc_d = presc_q + PW'(1);
        dig_d   = dig_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            dig_d   = (dig_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : dig_q + 3'd1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_reset_n) begin
            presc_q <= '0;
            dig_q   <= '0;
        end else begin
            presc_q <= presc_d;
            dig_q   <= dig_d;
        end
    end

    // A digit is a leading zero when it and every more-significant digit are zero.
    // The units digit is always lit so a zero result still shows "0".
    always_comb begin
        cur_code  = bcd_q[3:0];
        blank_cur = 1'b0;
        case (dig_q)
            3'd1: begin
                cur_code  = bcd_q[7:4];
                blank_cur = in_blank_zeros && (bcd_q[19:4] == '0);
            end
            3'd2: begin
                cur_code  = bcd_q[11:8];
                blank_cur = in_blank_zeros && (bcd_q[19:8] == '0);
            end
            3'd3: begin
                cur_code  = bcd_q[15:12];
                blank_cur = in_blank_zeros && (bcd_q[19:12] == '0);
            end
            3'd4: begin
                cur_code  = bcd_q[19:16];
                blank_cur = in_blank_zeros && (bcd_q[19:16] == '0);
            end
            default: begin
                cur_code  = bcd_q[3:0];
                blank_cur = 1'b0;
            end
        endcase
    end

    seg7_decoder u_seg7 (
        .in_code (cur_code),
        .out_seg (seg_raw)
    );

    assign an_sel  = NUM_DIGITS'(1) << dig_q;
    assign out_an  = blank_cur ? '1 : ~an_sel;
    assign out_seg = blank_cur ? SEG_BLANK : seg_raw;

endmodule

// File: tb/tb_bcd_display_controller.sv
// Self-checking bench for bcd_display_controller: vector table, random sweep, restart/reset/scan sequences.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_bcd_display_controller;

    logic        in_clk = 1'b0;
    logic        in_reset_n;
    logic [15:0] in_value;
    logic        in_start;
    logic        in_blank_zeros;
    logic        out_busy;
    logic        out_done;
    logic [19:0] out_bcd_value;
    logic [6:0]  out_seg;
    logic [4:0]  out_an;

    int errors = 0;
    int checks = 0;
    logic [19:0] sb[$];

    bcd_display_controller #(.SCAN_DIV(4)) dut (
        .in_clk         (in_clk),
        .in_reset_n     (in_reset_n),
        .in_value       (in_value),
        .in_start       (in_start),
        .in_blank_zeros (in_blank_zeros),
        .out_busy       (out_busy),
        .out_done       (out_done),
        .out_bcd_value  (out_bcd_value),
        .out_seg        (out_seg),
        .out_an         (out_an)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [15:0] v;
        logic [19:0] e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // One cycle; any done pulse is matched against the scoreboard.
    task automatic tick();
        logic [19:0] e;
        int bad;
        @(negedge in_clk);
        if (out_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("bcd_value", {12'd0, out_bcd_value}, {12'd0, e});
                bad = 0;
                for (int i = 0; i < 5; i++) if (out_bcd_value[4*i +: 4] > 4'd9) bad++;
                chk("nibble_range", bad, 0);
            end
        end
    endtask

    // Called from a negedge with the FSM in IDLE; returns at a negedge with the FSM in IDLE.
    task automatic run_conv(input logic [15:0] v, input logic [19:0] exp);
        int lat;
        int bcnt;
        in_value = v;
        in_start = 1'b1;
        sb.push_back(exp);
        tick();
        in_start = 1'b0;
        in_value = ~v;          // must not disturb the running conversion
        lat  = 1;
        bcnt = 0;
        while (!out_done && lat < 40) begin
            if (out_busy) bcnt++;
            tick();
            lat++;
        end
        chk("latency", lat, 17);
        chk("busy_cycles", bcnt, 16);
        tick();
    endtask

    initial begin
        vec_t vecs[8];
        logic [4:0] an_exp[5];
        logic [6:0] seg_exp[4];
        logic [4:0] prev_an;
        int n;
        int dones;
        logic [15:0] rv;

        vecs[0] = '{16'd0,     20'h00000};
        vecs[1] = '{16'd65535, 20'h65535};
        vecs[2] = '{16'd1234,  20'h01234};
        vecs[3] = '{16'd9999,  20'h09999};
        vecs[4] = '{16'd10000, 20'h10000};
        vecs[5] = '{16'd1,     20'h00001};
        vecs[6] = '{16'd99,    20'h00099};
        vecs[7] = '{16'd40960, 20'h40960};

        in_reset_n     = 1'b0;
        in_value       = '0;
        in_start       = 1'b0;
        in_blank_zeros = 1'b0;
        repeat (3) tick();
        chk("rst_busy", out_busy, 0);
        chk("rst_done", out_done, 0);
        chk("rst_bcd",  out_bcd_value, 0);
        chk("rst_an",   out_an, 5'b11110);
        chk("rst_seg",  out_seg, 7'b1000000);
        in_reset_n = 1'b1;
        tick();

        // Vector table.
        for (int i = 0; i < 8; i++) run_conv(vecs[i].v, vecs[i].e);

        // Random sweep against the /10 %10 model.
        for (int i = 0; i < 2000; i++) begin
            rv = 16'($urandom_range(0, 65535));
            run_conv(rv, to_bcd(rv));
        end

        // Second start 5 cycles into a conversion is ignored.
        in_value = 16'd100;
        in_start = 1'b1;
        sb.push_back(20'h00100);
        tick();
        in_start = 1'b0;
        in_value = 16'd5555;
        repeat (4) tick();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_done) dones++;
        end
        chk("restart_dones", dones, 1);

        // Start held high re-triggers only after returning to IDLE: two dones in 36 cycles.
        in_value = 16'd777;
        in_start = 1'b1;
        sb.push_back(20'h00777);
        sb.push_back(20'h00777);
        dones = 0;
        for (int k = 0; k < 36; k++) begin
            tick();
            if (out_done) dones++;
        end
        in_start = 1'b0;
        chk("held_start_dones", dones, 2);
        chk("held_start_idle", out_busy, 0);
        tick();

        // Reset during CONVERT cycle 8 aborts with no done.
        in_value = 16'd4321;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        repeat (7) tick();
        chk("abort_busy_before", out_busy, 1);
        in_reset_n = 1'b0;
        tick();
        chk("abort_busy", out_busy, 0);
        chk("abort_done", out_done, 0);
        chk("abort_bcd",  out_bcd_value, 0);
        chk("abort_an",   out_an, 5'b11110);
        in_reset_n = 1'b1;
        repeat (30) tick();
        chk("abort_bcd_after", out_bcd_value, 0);

        // Scan sequence with blanking for 01234.
        run_conv(16'd1234, 20'h01234);
        in_blank_zeros = 1'b1;
        an_exp  = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b11111};
        seg_exp = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        prev_an = out_an;
        n = 0;
        tick();
        while (!(out_an == 5'b11110 && prev_an != 5'b11110) && n < 100) begin
            prev_an = out_an;
            tick();
            n++;
        end
        chk("scan_sync", (n < 100) ? 1 : 0, 1);
        for (int j = 0; j < 20; j++) begin
            chk("scan_an", out_an, an_exp[j / 4]);
            if (j < 16) chk("scan_seg", out_seg, seg_exp[j / 4]);
            tick();
        end

        // Without blanking the leading zero is lit as "0".
        in_blank_zeros = 1'b0;
        n = 0;
        while (out_an != 5'b01111 && n < 40) begin
            tick();
            n++;
        end
        chk("noblank_an",  out_an, 5'b01111);
        chk("noblank_seg", out_seg, 7'b1000000);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
